// File: rtl/tt_sweep_capture_if.sv
// Signal bundle between the truth-table sweeper and its driver/observer.
// The netlist output y0 is carried here because the sweeper samples it.
interface tt_sweep_capture_if;
   logic        start;
   logic [15:0] expected_tt;
   logic [3:0]  x;
   logic        y0;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic        match;
   logic [4:0]  mismatch_cnt;
   logic [3:0]  first_fail;
   logic        first_fail_valid;

   modport master (
      output start, expected_tt, y0,
      input  x, busy, done, tt, match, mismatch_cnt, first_fail, first_fail_valid
   );

   modport slave (
      input  start, expected_tt, y0,
      output x, busy, done, tt, match, mismatch_cnt, first_fail, first_fail_valid
   );
endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps all 16 minterms of a 4-input netlist, captures its truth table and
// compares it bit-by-bit with a golden table captured at start.
module tt_sweep_capture #(
   parameter int unsigned SETTLE = 1
) (
   input logic               clk,
   input logic               rst,
   tt_sweep_capture_if.slave bus
);

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("tt_sweep_capture: SETTLE must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] SC_LAST = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  x_q, x_d;
   logic [3:0]  sc_q, sc_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] tt_q, tt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        match_q, match_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  ff_q, ff_d;
   logic        ffv_q, ffv_d;

   // NOTE: every variable gets a default before the case so no path through
   // the block leaves one unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      sc_d    = sc_q;
      exp_d   = exp_q;
      tt_d    = tt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      match_d = match_q;
      cnt_d   = cnt_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;

      unique case (state_q)
         IDLE: begin
            x_d    = 4'd0;
            busy_d = 1'b0;
            if (bus.start) begin
               exp_d   = bus.expected_tt;
               tt_d    = 16'd0;
               cnt_d   = 5'd0;
               ff_d    = 4'd0;
               ffv_d   = 1'b0;
               match_d = 1'b0;
               sc_d    = 4'd0;
               busy_d  = 1'b1;
               state_d = SWEEP;
            end
         end

         SWEEP: begin
            if (sc_q == SC_LAST) begin
               sc_d       = 4'd0;
               tt_d[x_q]  = bus.y0;
               if (bus.y0 != exp_q[x_q]) begin
                  cnt_d = cnt_q + 5'd1;
                  if (!ffv_q) begin
                     ff_d  = x_q;
                     ffv_d = 1'b1;
                  end
               end
               if (x_q == 4'd15) begin
                  // Final sample: results freeze here, x parks at 0 for DONE.
                  x_d     = 4'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  match_d = (cnt_d == 5'd0);
                  state_d = DONE;
               end else begin
                  x_d = x_q + 4'd1;
               end
            end else begin
               sc_d = sc_q + 4'd1;
            end
         end

         DONE: begin
            x_d     = 4'd0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            x_d     = 4'd0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= 4'd0;
         sc_q    <= 4'd0;
         exp_q   <= 16'd0;
         tt_q    <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         cnt_q   <= 5'd0;
         ff_q    <= 4'd0;
         ffv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         sc_q    <= sc_d;
         exp_q   <= exp_d;
         tt_q    <= tt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
      end
   end

   assign bus.x                = x_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.tt               = tt_q;
   assign bus.match            = match_q;
   assign bus.mismatch_cnt     = cnt_q;
   assign bus.first_fail       = ff_q;
   assign bus.first_fail_valid = ffv_q;

endmodule
